// File: rtl/demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// demux_route_ctrl
//
// Queues {dest, data} entries from an upstream valid/ready source. Each entry
// is then presented to a downstream 1x8 demultiplexer for a fixed number of
// cycles. The data bit goes out on D and the channel select on S. Entries
// leave the queue in arrival order. While the queue still holds work, one
// entry follows the next with no idle cycle between them.
//
// Parameters
//   HOLD_CYCLES  cycles each routed entry is held on D/S (1..15)
//   FIFO_DEPTH   queue capacity in entries (power of two, 2..16)
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream offers an entry
//   in_ready     queue has room (derived from the registered occupancy only)
//   in_dest      destination channel 0..7 of the offered entry
//   in_data      data bit of the offered entry
//   D            registered data bit to the demux
//   S            registered select to the demux
//   busy         high while an entry is being held on D/S
//   fifo_count   current queue occupancy, 0..FIFO_DEPTH
//   tx_count     (only with DEMUX_ROUTE_STAT_EN) 8-bit wrapping count of
//                entries popped from the queue
//
// Build option
//   DEMUX_ROUTE_STAT_EN  when defined, adds the tx_count output and counter.
// -----------------------------------------------------------------------------
module demux_route_ctrl #(
    parameter int HOLD_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_dest,
    input  logic       in_data,
    output logic       D,
    output logic [2:0] S,
    output logic       busy,
    output logic [4:0] fifo_count
`ifdef DEMUX_ROUTE_STAT_EN
    ,
    output logic [7:0] tx_count
`endif
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [4:0]       DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Queue storage. It has no reset: after a reset the pointers and count
    // are cleared, so any old contents can no longer be read.
    logic [2:0] mem_dest [FIFO_DEPTH];
    logic       mem_data [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [4:0]       count_reg;
    logic [4:0]       count_next;

    logic [3:0] hold_cnt_reg;
    logic [3:0] hold_cnt_next;
    logic       d_reg;
    logic       d_next;
    logic [2:0] s_reg;
    logic [2:0] s_next;
    logic       busy_reg;
    logic       busy_next;

    logic push;
    logic pop;
    logic queue_empty;

    // in_ready looks only at the registered occupancy. A pop in the same
    // cycle therefore never lets a push into a full queue.
    assign in_ready    = (count_reg < DEPTH_CNT);
    assign push        = in_valid && in_ready;
    assign queue_empty = (count_reg == 5'd0);

    // -------------------------------------------------------------------------
    // Queue write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr_reg] <= in_dest;
            mem_data[wr_ptr_reg] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy. FIFO_DEPTH is a power of two, so the pointers
    // wrap on their own when they overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 5'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Route FSM: next state and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        d_next        = d_reg;
        s_next        = s_reg;
        busy_next     = busy_reg;
        pop           = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (!queue_empty) begin
                    pop           = 1'b1;
                    state_next    = HOLD;
                    d_next        = mem_data[rd_ptr_reg];
                    s_next        = mem_dest[rd_ptr_reg];
                    busy_next     = 1'b1;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt_reg != 4'd0) begin
                    hold_cnt_next = hold_cnt_reg - 4'd1;
                end else if (!queue_empty) begin
                    // Back-to-back: load the next entry without an IDLE cycle.
                    pop           = 1'b1;
                    d_next        = mem_data[rd_ptr_reg];
                    s_next        = mem_dest[rd_ptr_reg];
                    busy_next     = 1'b1;
                    hold_cnt_next = HOLD_LOAD;
                end else begin
                    // S keeps the last select so the demux does not switch
                    // while D is low.
                    state_next = IDLE;
                    d_next     = 1'b0;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 4'd0;
            d_reg        <= 1'b0;
            s_reg        <= 3'd0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            d_reg        <= d_next;
            s_reg        <= s_next;
            busy_reg     <= busy_next;
        end
    end

    assign D          = d_reg;
    assign S          = s_reg;
    assign busy       = busy_reg;
    assign fifo_count = count_reg;

`ifdef DEMUX_ROUTE_STAT_EN
    // -------------------------------------------------------------------------
    // Count of popped entries. Eight bits, so it wraps from 255 back to 0.
    // -------------------------------------------------------------------------
    logic [7:0] tx_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_reg <= 8'd0;
        end else if (pop) begin
            tx_count_reg <= tx_count_reg + 8'd1;
        end
    end

    assign tx_count = tx_count_reg;
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_route_ctrl
//
// Directed bench for demux_route_ctrl at its default parameters
// (HOLD_CYCLES=2, FIFO_DEPTH=4). Expected values are hand-computed tables.
// Outputs are sampled 1 time unit after each rising edge.
// Build option DEMUX_ROUTE_STAT_EN also exercises tx_count.
// -----------------------------------------------------------------------------
module tb_demux_route_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_dest;
    logic       in_data;
    logic       D;
    logic [2:0] S;
    logic       busy;
    logic [4:0] fifo_count;
`ifdef DEMUX_ROUTE_STAT_EN
    logic [7:0] tx_count;
`endif

    int total;
    int bad;

    // Scenario 2: pushes of dests 0,3,7,2. Expected values after each edge.
    int s2_dest [4]  = '{0, 3, 7, 2};
    int s2_data [4]  = '{1, 0, 1, 1};
    int s2_busy [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int s2_s    [10] = '{5, 0, 0, 3, 3, 7, 7, 2, 2, 2};
    int s2_d    [10] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    int s2_cnt  [10] = '{1, 1, 2, 2, 2, 1, 1, 0, 0, 0};

    // Scenario 3: in_valid held high for 14 edges. The tables give the
    // acceptance pattern and the occupancy after each edge.
    int s3_acc [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0};
    int s3_cnt [22] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3, 4, 3, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0};

    int idx;
    int ent;
    int sent;
    logic acc;
    logic drained;

    demux_route_ctrl #(
        .HOLD_CYCLES(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .D         (D),
        .S         (S),
        .busy      (busy),
        .fifo_count(fifo_count)
`ifdef DEMUX_ROUTE_STAT_EN
        ,
        .tx_count  (tx_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_dest  = 3'd0;
        in_data  = 1'b0;

        // ---------------- Reset state ----------------
        #1 rst_n = 1'b0;
        #1;
        chk("rst_D", 8'(D), 8'd0);
        chk("rst_S", 8'(S), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_count", 8'(fifo_count), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd1);
`ifdef DEMUX_ROUTE_STAT_EN
        chk("rst_tx", tx_count, 8'd0);
`endif
        #1 rst_n = 1'b1;

        // ---------------- Scenario 1: single push dest=5 data=1 ----------------
        // The push lands on the first edge after reset is released.
        in_valid = 1'b1;
        in_dest  = 3'd5;
        in_data  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1_push_count", 8'(fifo_count), 8'd1);
        chk("s1_push_busy", 8'(busy), 8'd0);
        tick();
        chk("s1_c1_S", 8'(S), 8'd5);
        chk("s1_c1_D", 8'(D), 8'd1);
        chk("s1_c1_busy", 8'(busy), 8'd1);
        chk("s1_c1_count", 8'(fifo_count), 8'd0);
        tick();
        chk("s1_c2_S", 8'(S), 8'd5);
        chk("s1_c2_D", 8'(D), 8'd1);
        chk("s1_c2_busy", 8'(busy), 8'd1);
        tick();
        chk("s1_idle_S", 8'(S), 8'd5);
        chk("s1_idle_D", 8'(D), 8'd0);
        chk("s1_idle_busy", 8'(busy), 8'd0);

        // ---------------- Scenario 2: four back-to-back pushes ----------------
        // At edge 4 the occupancy is 2 and a push and a pop happen together,
        // so the count must stay at 2.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4) begin
                in_valid = 1'b1;
                in_dest  = 3'(s2_dest[k-1]);
                in_data  = 1'(s2_data[k-1]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk($sformatf("s2_busy_%0d", k), 8'(busy), 8'(s2_busy[k-1]));
            chk($sformatf("s2_S_%0d", k), 8'(S), 8'(s2_s[k-1]));
            chk($sformatf("s2_D_%0d", k), 8'(D), 8'(s2_d[k-1]));
            chk($sformatf("s2_count_%0d", k), 8'(fifo_count), 8'(s2_cnt[k-1]));
        end

        // ---------------- Scenario 3: fill to full with in_valid held ----------------
        // Entry idx carries dest idx%8 and data (idx%3==0). An offer that is
        // refused stays on the inputs until it is accepted.
        idx = 0;
        for (int k = 1; k <= 22; k++) begin
            if (k <= 14) begin
                in_valid = 1'b1;
                in_dest  = 3'(idx % 8);
                in_data  = (idx % 3 == 0);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k <= 14 && s3_acc[k-1] == 1) idx++;
            chk($sformatf("s3_count_%0d", k), 8'(fifo_count), 8'(s3_cnt[k-1]));
            chk($sformatf("s3_ready_%0d", k), 8'(in_ready), 8'(s3_cnt[k-1] < 4));
            if (k >= 2 && k <= 21) begin
                ent = (k - 2) / 2;
                chk($sformatf("s3_busy_%0d", k), 8'(busy), 8'd1);
                chk($sformatf("s3_S_%0d", k), 8'(S), 8'(ent % 8));
                chk($sformatf("s3_D_%0d", k), 8'(D), 8'(ent % 3 == 0));
            end else if (k == 22) begin
                chk("s3_end_busy", 8'(busy), 8'd0);
                chk("s3_end_D", 8'(D), 8'd0);
                chk("s3_end_S", 8'(S), 8'd1);
            end else begin
                chk("s3_first_busy", 8'(busy), 8'd0);
            end
        end

        // ---------------- Scenario 4: reset mid-HOLD with 3 queued ----------------
        in_valid = 1'b1;
        in_data  = 1'b1;
        in_dest  = 3'd4; tick();
        in_dest  = 3'd5; tick();
        in_dest  = 3'd6; tick();
        in_dest  = 3'd1; tick();
        in_dest  = 3'd3; tick();
        in_valid = 1'b0;
        chk("s4_pre_count", 8'(fifo_count), 8'd3);
        chk("s4_pre_busy", 8'(busy), 8'd1);
        chk("s4_pre_S", 8'(S), 8'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("s4_rst_D", 8'(D), 8'd0);
        chk("s4_rst_S", 8'(S), 8'd0);
        chk("s4_rst_busy", 8'(busy), 8'd0);
        chk("s4_rst_count", 8'(fifo_count), 8'd0);
        tick();
        chk("s4_rst_hold_busy", 8'(busy), 8'd0);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("s4_after_busy_%0d", k), 8'(busy), 8'd0);
            chk($sformatf("s4_after_D_%0d", k), 8'(D), 8'd0);
            chk($sformatf("s4_after_count_%0d", k), 8'(fifo_count), 8'd0);
        end
        // A new push after the reset is routed normally.
        in_valid = 1'b1;
        in_dest  = 3'd3;
        in_data  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s4_new_count", 8'(fifo_count), 8'd1);
        tick();
        chk("s4_new_S", 8'(S), 8'd3);
        chk("s4_new_D", 8'(D), 8'd1);
        chk("s4_new_busy", 8'(busy), 8'd1);

`ifdef DEMUX_ROUTE_STAT_EN
        // ---------------- Scenario 5: tx_count wrap ----------------
        // One entry has been popped since the reset. Routing 256 more brings
        // the total to 257, and the 8-bit count wraps to 1.
        chk("s5_tx_first", tx_count, 8'd1);
        sent = 0;
        for (int c = 0; c < 3000 && sent < 256; c++) begin
            in_valid = 1'b1;
            in_dest  = 3'(sent % 8);
            in_data  = 1'(sent % 2);
            acc      = in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("s5_sent", 8'(sent == 256), 8'd1);
        drained = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (busy == 1'b0 && fifo_count == 5'd0) begin
                drained = 1'b1;
                break;
            end
            tick();
        end
        chk("s5_drained", 8'(drained), 8'd1);
        chk("s5_tx_wrap", tx_count, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
